// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the encoder state type used by the polynomial packing blocks.
package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEF_W  = 16;

    typedef enum logic [1:0] {
        ENC_IDLE  = 2'd0,
        ENC_RUN   = 2'd1,
        ENC_FLUSH = 2'd2,
        ENC_DONE  = 2'd3
    } enc_state_t;

endpackage

// File: rtl/poly_encode_norm.sv
// Single-lane reduction of a signed coefficient in (-Q, 2Q) to [0, Q).
// Instantiated by poly_encode only when NORMALIZE_EN is defined.
module poly_encode_norm
    import kyber_pkg::*;
#(
    parameter int Q = KYBER_Q
) (
    input  logic signed [COEF_W-1:0] i_coef,
    output logic        [COEF_W-1:0] o_coef
);

    localparam logic signed [COEF_W-1:0] Q_S = COEF_W'(Q);

    always_comb begin
        o_coef = i_coef;
        if (i_coef[COEF_W-1]) begin
            o_coef = i_coef + Q_S;
        end else if (i_coef >= Q_S) begin
            o_coef = i_coef - Q_S;
        end
    end

endmodule

// File: rtl/poly_encode.sv
// Packs two signed coefficients per beat into an LSB-first word stream (ByteEncode_d).
// Optional macro NORMALIZE_EN reduces each lane to [0, Q) before packing.
module poly_encode
    import kyber_pkg::*;
#(
    parameter int N_COEF    = KYBER_N,
    parameter int COEF_BITS = 12,
    parameter int WORD_W    = 32,
    parameter int Q         = KYBER_Q
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     set,
    input  logic signed [COEF_W-1:0] din_1,
    input  logic signed [COEF_W-1:0] din_2,
    input  logic                     readin,
    output logic                     ok_in,
    output logic [WORD_W-1:0]        dout,
    output logic                     ok_out,
    input  logic                     readout,
    output logic                     done
);

    localparam int BUF_W  = WORD_W + 2*COEF_BITS - 1;
    localparam int CNT_W  = $clog2(WORD_W + 2*COEF_BITS);
    localparam int BEAT_W = $clog2(N_COEF/2 + 1);

    localparam logic [CNT_W-1:0]  WORD_W_C  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0]  BEAT_BITS = CNT_W'(2*COEF_BITS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_COEF/2 - 1);

    enc_state_t        r_state;
    logic [BUF_W-1:0]  r_buf;
    logic [CNT_W-1:0]  r_held;
    logic [BEAT_W-1:0] r_beats;
    logic              r_done;

    logic [COEF_W-1:0] w_lane1;
    logic [COEF_W-1:0] w_lane2;
    logic [BUF_W-1:0]  w_beat_bits;
    logic [BUF_W-1:0]  w_shifted;
    logic [BUF_W-1:0]  w_buf_next;
    logic [CNT_W-1:0]  w_held_after;
    logic [CNT_W-1:0]  w_held_next;
    logic              w_accept;
    logic              w_emit;
    logic              w_unused_bits;

`ifdef NORMALIZE_EN
    poly_encode_norm #(.Q(Q)) u_norm1 (.i_coef(din_1), .o_coef(w_lane1));
    poly_encode_norm #(.Q(Q)) u_norm2 (.i_coef(din_2), .o_coef(w_lane2));
    assign w_unused_bits = ^{w_lane1, w_lane2};
`else
    assign w_lane1       = din_1;
    assign w_lane2       = din_2;
    assign w_unused_bits = ^{w_lane1, w_lane2, COEF_W'(Q)};
`endif

    assign w_beat_bits = BUF_W'({w_lane2[COEF_BITS-1:0], w_lane1[COEF_BITS-1:0]});

    assign ok_in  = (r_state == ENC_RUN) && (r_held < WORD_W_C);
    assign ok_out = ((r_state == ENC_RUN) && (r_held >= WORD_W_C)) ||
                    ((r_state == ENC_FLUSH) && (r_held != '0));
    assign dout   = r_buf[WORD_W-1:0];
    assign done   = r_done;

    assign w_accept = ok_in && readin;
    assign w_emit   = ok_out && readout;

    // Emit shifts first so a same-cycle beat lands at the post-shift fill level.
    always_comb begin
        w_shifted    = r_buf;
        w_held_after = r_held;
        if (w_emit) begin
            w_shifted    = r_buf >> WORD_W;
            w_held_after = (r_held >= WORD_W_C) ? (r_held - WORD_W_C) : '0;
        end
        w_buf_next  = w_shifted;
        w_held_next = w_held_after;
        if (w_accept) begin
            w_buf_next  = w_shifted | (w_beat_bits << w_held_after);
            w_held_next = w_held_after + BEAT_BITS;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ENC_IDLE;
            r_buf   <= '0;
            r_held  <= '0;
            r_beats <= '0;
            r_done  <= 1'b0;
        end else if (!set) begin
            r_state <= ENC_IDLE;
            r_buf   <= '0;
            r_held  <= '0;
            r_beats <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == ENC_DONE);
            case (r_state)
                ENC_IDLE: begin
                    r_state <= ENC_RUN;
                    r_buf   <= '0;
                    r_held  <= '0;
                    r_beats <= '0;
                end
                ENC_RUN: begin
                    r_buf  <= w_buf_next;
                    r_held <= w_held_next;
                    if (w_accept) begin
                        r_beats <= r_beats + BEAT_W'(1);
                        if (r_beats == LAST_BEAT) begin
                            r_state <= ENC_FLUSH;
                        end
                    end
                end
                ENC_FLUSH: begin
                    r_buf  <= w_buf_next;
                    r_held <= w_held_next;
                    if (r_held == '0) begin
                        r_state <= ENC_DONE;
                    end
                end
                ENC_DONE: begin
                    r_state <= ENC_DONE;
                end
                default: begin
                    r_state <= ENC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_encode.sv
// Directed self-checking bench for poly_encode: full frames, backpressure, abort, async reset,
// lane normalization (expectation follows NORMALIZE_EN) and a small 4-bit frame.
module tb_poly_encode;

    logic               clk = 1'b0;
    logic               reset;
    logic               set;
    logic signed [15:0] din_1;
    logic signed [15:0] din_2;
    logic               readin;
    logic               ok_in;
    logic [31:0]        dout;
    logic               ok_out;
    logic               readout;
    logic               done;

    logic               sSet;
    logic signed [15:0] sDin1;
    logic signed [15:0] sDin2;
    logic               sReadin;
    logic               sOkIn;
    logic [31:0]        sDout;
    logic               sOkOut;
    logic               sDone;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poly_encode dut (
        .clk(clk), .reset(reset), .set(set), .din_1(din_1), .din_2(din_2),
        .readin(readin), .ok_in(ok_in), .dout(dout), .ok_out(ok_out),
        .readout(readout), .done(done)
    );

    poly_encode #(.N_COEF(6), .COEF_BITS(4)) dutSmall (
        .clk(clk), .reset(reset), .set(sSet), .din_1(sDin1), .din_2(sDin2),
        .readin(sReadin), .ok_in(sOkIn), .dout(sDout), .ok_out(sOkOut),
        .readout(readout), .done(sDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference packing: stream bit s belongs to coefficient s/12, whose value is index+1.
    function automatic logic [31:0] expWord(input int k);
        logic [31:0] w;
        logic [15:0] v;
        w = '0;
        for (int b = 0; b < 32; b++) begin
            int s;
            int c;
            s = k*32 + b;
            c = s / 12;
            v = 16'(c + 1);
            w[b] = (c < 256) ? v[s % 12] : 1'b0;
        end
        return w;
    endfunction

    task automatic applyStimulus(input bit randIn, input bit randOut);
        int beat    = 0;
        int words   = 0;
        int cyc     = 0;
        int overlap = 0;
        set = 1'b1;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            readin  = randIn  ? 1'($urandom_range(0, 1)) : 1'b1;
            readout = randOut ? 1'($urandom_range(0, 1)) : 1'b1;
            din_1   = 16'(2*beat + 1);
            din_2   = 16'(2*beat + 2);
            #1;
            if (ok_in && ok_out) overlap++;
            if (ok_out && readout) begin
                checkOutput("word", dout, expWord(words));
                words++;
            end
            if (ok_in && readin) beat++;
            cyc++;
        end
        checkOutput("wordCount", 32'(words), 32'd96);
        checkOutput("doneAfterFrame", {31'd0, done}, 32'd1);
        checkOutput("inWhileFull", 32'(overlap), 32'd0);
        checkOutput("quietInDone", {30'd0, ok_in, ok_out}, 32'd0);
        set    = 1'b0;
        readin = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("doneCleared", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int beat;
        int cyc;
        int words;
        reset = 1'b0; set = 1'b0; readin = 1'b0; readout = 1'b0; din_1 = '0; din_2 = '0;
        sSet = 1'b0; sReadin = 1'b0; sDin1 = '0; sDin2 = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstOkIn", {31'd0, ok_in}, 32'd0);
        checkOutput("rstOkOut", {31'd0, ok_out}, 32'd0);
        checkOutput("rstDout", dout, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Full frame with free-flowing handshakes, then random stalls on both sides.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);

        // Abort after 40 beats, then a fresh frame must start from an empty buffer.
        set = 1'b1; readin = 1'b1; readout = 1'b1; beat = 0; cyc = 0;
        while (beat < 40 && cyc < 200) begin
            @(negedge clk);
            din_1 = 16'(2*beat + 1);
            din_2 = 16'(2*beat + 2);
            #1;
            if (ok_in && readin) beat++;
            cyc++;
        end
        @(negedge clk);
        set = 1'b0; readin = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abortOkIn", {31'd0, ok_in}, 32'd0);
        checkOutput("abortOkOut", {31'd0, ok_out}, 32'd0);
        checkOutput("abortDone", {31'd0, done}, 32'd0);
        checkOutput("abortDout", dout, 32'd0);
        applyStimulus(1'b0, 1'b0);

        // Fill past one word with readout held low, then pulse reset between edges.
        set = 1'b1; readin = 1'b1; readout = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            din_1 = 16'(2*c + 1);
            din_2 = 16'(2*c + 2);
        end
        #1;
        checkOutput("stallOkOut", {31'd0, ok_out}, 32'd1);
        checkOutput("stallOkIn", {31'd0, ok_in}, 32'd0);
        checkOutput("firstWord", dout, 32'h03002001);
        reset = 1'b0;
        #1;
        checkOutput("asyncOkIn", {31'd0, ok_in}, 32'd0);
        checkOutput("asyncOkOut", {31'd0, ok_out}, 32'd0);
        checkOutput("asyncDout", dout, 32'd0);
        checkOutput("asyncDone", {31'd0, done}, 32'd0);
        set = 1'b0; readin = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Out-of-range lane values: normalized or raw low bits depending on the build.
        set = 1'b1; readin = 1'b1; readout = 1'b1;
        @(negedge clk);
        din_1 = -16'sd1; din_2 = 16'sd3330;
        @(negedge clk);
        din_1 = '0; din_2 = '0;
        cyc = 0;
        #1;
        while (!ok_out && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
`ifdef NORMALIZE_EN
        checkOutput("normWord", {8'd0, dout[23:0]}, 32'h00001D00);
`else
        checkOutput("rawWord", {8'd0, dout[23:0]}, 32'h00D02FFF);
`endif
        set = 1'b0; readin = 1'b0;
        @(negedge clk);

        // Six 4-bit coefficients give a single zero-padded word.
        sSet = 1'b1; readout = 1'b1; beat = 0; words = 0; cyc = 0;
        while (!sDone && cyc < 40) begin
            @(negedge clk);
            sReadin = (beat < 3);
            sDin1   = 16'(2*beat + 1);
            sDin2   = 16'(2*beat + 2);
            #1;
            if (sOkOut && readout) begin
                checkOutput("smallWord", sDout, 32'h00654321);
                words++;
            end
            if (sOkIn && sReadin) beat++;
            cyc++;
        end
        checkOutput("smallWordCount", 32'(words), 32'd1);
        checkOutput("smallDone", {31'd0, sDone}, 32'd1);
        sSet = 1'b0; sReadin = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
